// File: rtl/axi_slave_axis_pkg.sv
// rtl/axi_slave_axis_pkg.sv - shared FSM encodings and response codes for axi_slave_axis
package axi_slave_axis_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // AXI size code that matches a full-width beat of data_w bits
    function automatic logic [2:0] beat_size(input int data_w);
        beat_size = 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/axi_slave_axis_beat_cnt.sv
// rtl/axi_slave_axis_beat_cnt.sv - saturating beat counter with clear and enable
module axi_slave_axis_beat_cnt #(
    parameter int CNT_W = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_cnt <= '0;
        end else if (en_i && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/axi_slave_axis.sv
// rtl/axi_slave_axis.sv - AXI slave bridging write bursts to a stream out and a stream in to read bursts
module axi_slave_axis
    import axi_slave_axis_pkg::*;
#(
    parameter int AXI_ADDR_W = 24,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_ID_W   = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic [AXI_ID_W-1:0]     axi_awid_i,
    input  logic [AXI_ADDR_W-1:0]   axi_awaddr_i,
    input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
    input  logic [2:0]              axi_awsize_i,
    input  logic                    axi_awvalid_i,
    output logic                    axi_awready_o,

    input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
    input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
    input  logic                    axi_wlast_i,
    input  logic                    axi_wvalid_i,
    output logic                    axi_wready_o,

    output logic [AXI_ID_W-1:0]     axi_bid_o,
    output logic [1:0]              axi_bresp_o,
    output logic                    axi_bvalid_o,
    input  logic                    axi_bready_i,

    input  logic [AXI_ID_W-1:0]     axi_arid_i,
    input  logic [AXI_ADDR_W-1:0]   axi_araddr_i,
    input  logic [AXI_LEN_W-1:0]    axi_arlen_i,
    input  logic [2:0]              axi_arsize_i,
    input  logic                    axi_arvalid_i,
    output logic                    axi_arready_o,

    output logic [AXI_ID_W-1:0]     axi_rid_o,
    output logic [AXI_DATA_W-1:0]   axi_rdata_o,
    output logic [1:0]              axi_rresp_o,
    output logic                    axi_rlast_o,
    output logic                    axi_rvalid_o,
    input  logic                    axi_rready_i,

    output logic [AXI_DATA_W-1:0]   axis_out_data_o,
    output logic [AXI_ADDR_W-1:0]   axis_out_addr_o,
    output logic                    axis_out_last_o,
    output logic                    axis_out_valid_o,
    input  logic                    axis_out_ready_i,

    input  logic [AXI_DATA_W-1:0]   axis_in_data_i,
    input  logic                    axis_in_valid_i,
    output logic                    axis_in_ready_o
);

    localparam logic [2:0] SIZE_OK = beat_size(AXI_DATA_W);

    w_state_e                r_w_state;
    r_state_e                r_r_state;
    logic [AXI_ID_W-1:0]     r_awid;
    logic [AXI_ADDR_W-1:0]   r_awaddr;
    logic [AXI_LEN_W-1:0]    r_awlen;
    logic                    r_w_err;
    logic [AXI_ID_W-1:0]     r_arid;
    logic [AXI_LEN_W-1:0]    r_arlen;
    logic                    r_r_err;

    logic [AXI_LEN_W:0]      w_w_cnt;
    logic [AXI_LEN_W:0]      w_r_cnt;

    // Every handshake output is held low while reset is asserted
    logic w_run;
    logic w_w_idle, w_w_data, w_w_resp, w_r_idle, w_r_data;
    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic w_w_cnt_match, w_rlast;

    assign w_run    = !rst_i;
    assign w_w_idle = w_run && (r_w_state == W_IDLE);
    assign w_w_data = w_run && (r_w_state == W_DATA);
    assign w_w_resp = w_run && (r_w_state == W_RESP);
    assign w_r_idle = w_run && (r_r_state == R_IDLE);
    assign w_r_data = w_run && (r_r_state == R_DATA);

    assign w_aw_hs = w_w_idle && axi_awvalid_i;
    assign w_w_hs  = w_w_data && axi_wvalid_i && axis_out_ready_i;
    assign w_b_hs  = w_w_resp && axi_bready_i;
    assign w_ar_hs = w_r_idle && axi_arvalid_i;
    assign w_r_hs  = w_r_data && axis_in_valid_i && axi_rready_i;

    assign w_w_cnt_match = (w_w_cnt == {1'b0, r_awlen});
    assign w_rlast       = w_r_data && (w_r_cnt == {1'b0, r_arlen});

    axi_slave_axis_beat_cnt #(.CNT_W(AXI_LEN_W + 1)) u_w_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (w_aw_hs),
        .en_i  (w_w_hs),
        .cnt_o (w_w_cnt)
    );

    axi_slave_axis_beat_cnt #(.CNT_W(AXI_LEN_W + 1)) u_r_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (w_ar_hs),
        .en_i  (w_r_hs),
        .cnt_o (w_r_cnt)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_w_state <= W_IDLE;
            r_awid    <= '0;
            r_awaddr  <= '0;
            r_awlen   <= '0;
            r_w_err   <= 1'b0;
        end else begin
            case (r_w_state)
                W_IDLE: if (w_aw_hs) begin
                    r_awid    <= axi_awid_i;
                    r_awaddr  <= axi_awaddr_i;
                    r_awlen   <= axi_awlen_i;
                    r_w_err   <= (axi_awsize_i != SIZE_OK);
                    r_w_state <= W_DATA;
                end
                // The burst only ends on wlast; a wlast on the wrong beat flags an error
                W_DATA: if (w_w_hs && axi_wlast_i) begin
                    if (!w_w_cnt_match) r_w_err <= 1'b1;
                    r_w_state <= W_RESP;
                end
                W_RESP: if (w_b_hs) r_w_state <= W_IDLE;
                default: r_w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_r_state <= R_IDLE;
            r_arid    <= '0;
            r_arlen   <= '0;
            r_r_err   <= 1'b0;
        end else begin
            case (r_r_state)
                R_IDLE: if (w_ar_hs) begin
                    r_arid    <= axi_arid_i;
                    r_arlen   <= axi_arlen_i;
                    r_r_err   <= (axi_arsize_i != SIZE_OK);
                    r_r_state <= R_DATA;
                end
                R_DATA: if (w_r_hs && w_rlast) r_r_state <= R_IDLE;
                default: r_r_state <= R_IDLE;
            endcase
        end
    end

    assign axi_awready_o    = w_w_idle;
    assign axi_wready_o     = w_w_data && axis_out_ready_i;
    assign axis_out_valid_o = w_w_data && axi_wvalid_i;
    assign axis_out_data_o  = axi_wdata_i;
    assign axis_out_last_o  = w_w_data && axi_wlast_i;
    assign axis_out_addr_o  = r_awaddr;

    assign axi_bvalid_o = w_w_resp;
    assign axi_bid_o    = r_awid;
    assign axi_bresp_o  = r_w_err ? RESP_SLVERR : RESP_OKAY;

    assign axi_arready_o   = w_r_idle;
    assign axi_rvalid_o    = w_r_data && axis_in_valid_i;
    assign axis_in_ready_o = w_r_data && axi_rready_i;
    assign axi_rdata_o     = axis_in_data_i;
    assign axi_rid_o       = r_arid;
    assign axi_rresp_o     = r_r_err ? RESP_SLVERR : RESP_OKAY;
    assign axi_rlast_o     = w_rlast;

    // Write strobes and read address carry no meaning for a stream bridge
    logic w_unused_ok;
    assign w_unused_ok = ^{axi_wstrb_i, axi_araddr_i};

endmodule
